// File: rtl/chaosheng_ceju.sv
// Ultrasonic ranging controller: periodic trigger, echo-width measurement with timeout,
// and a debounced near-obstacle flag that changes only after CONFIRM agreeing results.
module chaosheng_ceju #(
  parameter int TRIG_CYC    = 500,
  parameter int PERIOD_CYC  = 3000000,
  parameter int TIMEOUT_CYC = 1500000,
  parameter int THRESH_CYC  = 58300,
  parameter int CONFIRM     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        EN_D,
  input  logic        ECHO,
  output logic        TRIG,
  output logic        DIN1,
  output logic [20:0] DIST,
  output logic        VALID,
  output logic        TOUT
);

  localparam int PW   = $clog2(PERIOD_CYC + 1);
  localparam int CMAX = (TRIG_CYC > TIMEOUT_CYC) ? TRIG_CYC : TIMEOUT_CYC;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [PW-1:0] P_LAST  = PW'(PERIOD_CYC - 1);
  localparam logic [CW-1:0] T_LAST  = CW'(TRIG_CYC - 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYC - 1);
  localparam logic [20:0]   W_MAX   = '1;
  localparam logic [20:0]   W_NEAR  = 21'(THRESH_CYC);
  localparam logic [2:0]    N_CONF  = 3'(CONFIRM);

  typedef enum logic [2:0] {S_IDLE, S_TRIG, S_WAIT_RISE, S_MEASURE, S_DONE} state_t;

  state_t        state_q, state_d;
  logic          echo_m_q, echo_s_q;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [20:0]   width_q, width_d;
  logic [2:0]    agree_q, agree_d;
  logic          trig_q, trig_d;
  logic          din1_q, din1_d;
  logic [20:0]   dist_q, dist_d;
  logic          valid_q, valid_d;
  logic          tout_q, tout_d;
  logic          done_go, done_to, near;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    width_d = width_q;
    agree_d = agree_q;
    trig_d  = trig_q;
    din1_d  = din1_q;
    dist_d  = dist_q;
    tout_d  = tout_q;
    valid_d = 1'b0;
    done_go = 1'b0;
    done_to = 1'b0;
    near    = 1'b0;
    // Period counter parks at its last value so a late measurement triggers on IDLE entry.
    pcnt_d  = (pcnt_q == P_LAST) ? pcnt_q : pcnt_q + PW'(1);

    case (state_q)
      S_IDLE: begin
        if (EN_D) begin
          pcnt_d = '0;
        end else if (pcnt_q == P_LAST) begin
          state_d = S_TRIG;
          trig_d  = 1'b1;
          cnt_d   = '0;
          pcnt_d  = '0;
        end
      end
      S_TRIG: begin
        if (cnt_q == T_LAST) begin
          state_d = S_WAIT_RISE;
          trig_d  = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WAIT_RISE: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == TO_LAST) begin
          done_go = 1'b1;
          done_to = 1'b1;
        end else if (echo_s_q) begin
          state_d = S_MEASURE;
          width_d = '0;
        end
      end
      S_MEASURE: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == TO_LAST) begin
          done_go = 1'b1;
          done_to = 1'b1;
        end else if (!echo_s_q) begin
          done_go = 1'b1;
        end else if (width_q != W_MAX) begin
          width_d = width_q + 21'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (done_go) begin
      state_d = S_DONE;
      valid_d = 1'b1;
      tout_d  = done_to;
      dist_d  = done_to ? W_MAX : width_q;
      near    = !done_to && (width_q < W_NEAR);
      if (near == din1_q) begin
        agree_d = '0;
      end else if (agree_q + 3'd1 == N_CONF) begin
        din1_d  = near;
        agree_d = '0;
      end else begin
        agree_d = agree_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      echo_m_q <= 1'b0;
      echo_s_q <= 1'b0;
      pcnt_q   <= '0;
      cnt_q    <= '0;
      width_q  <= '0;
      agree_q  <= '0;
      trig_q   <= 1'b0;
      din1_q   <= 1'b0;
      dist_q   <= '0;
      valid_q  <= 1'b0;
      tout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      echo_m_q <= ECHO;
      echo_s_q <= echo_m_q;
      pcnt_q   <= pcnt_d;
      cnt_q    <= cnt_d;
      width_q  <= width_d;
      agree_q  <= agree_d;
      trig_q   <= trig_d;
      din1_q   <= din1_d;
      dist_q   <= dist_d;
      valid_q  <= valid_d;
      tout_q   <= tout_d;
    end
  end

  assign TRIG  = trig_q;
  assign DIN1  = din1_q;
  assign DIST  = dist_q;
  assign VALID = valid_q;
  assign TOUT  = tout_q;

endmodule

// File: tb/tb_chaosheng_ceju.sv
// Directed bench for chaosheng_ceju: expected results are queued when echoes are driven
// and checked when VALID strobes; trigger timing is checked against fixed cycle counts.
module tb_chaosheng_ceju;

  localparam int TRIG_CYC = 5, PERIOD_CYC = 200, TIMEOUT_CYC = 100, THRESH_CYC = 40, CONFIRM = 2;
  localparam int DMAX = 2097151;

  logic clk = 1'b0, rst, EN_D, ECHO;
  logic TRIG, DIN1, VALID, TOUT;
  logic [20:0] DIST;

  chaosheng_ceju #(
    .TRIG_CYC(TRIG_CYC), .PERIOD_CYC(PERIOD_CYC), .TIMEOUT_CYC(TIMEOUT_CYC),
    .THRESH_CYC(THRESH_CYC), .CONFIRM(CONFIRM)
  ) dut (
    .clk(clk), .rst(rst), .EN_D(EN_D), .ECHO(ECHO),
    .TRIG(TRIG), .DIN1(DIN1), .DIST(DIST), .VALID(VALID), .TOUT(TOUT)
  );

  always #5 clk = ~clk;

  typedef struct {
    string tag;
    int    dmin;
    int    dmax;
    bit    tout;
    bit    din1;
  } exp_t;

  exp_t sb[$];
  int ncmp = 0, nfail = 0;
  int cyc = 0, rise_cyc = 0, fall_cyc = 0, rise_cnt = 0, fall_cnt = 0, valid_cyc = 0;
  logic trig_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (TRIG === 1'b1 && trig_prev === 1'b0) begin
      rise_cnt = rise_cnt + 1;
      rise_cyc = cyc;
    end
    if (TRIG === 1'b0 && trig_prev === 1'b1) begin
      fall_cnt = fall_cnt + 1;
      fall_cyc = cyc;
    end
    trig_prev = TRIG;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input longint obs, input longint exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic expire(input string tag);
    ncmp++;
    nfail++;
    $error("FAIL %s: observed no event expected event within bound", tag);
  endtask

  task automatic wait_fall(input string tag);
    int f0 = fall_cnt;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (fall_cnt != f0) return;
    end
    expire(tag);
  endtask

  task automatic wait_rise(input string tag);
    int r0 = rise_cnt;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (rise_cnt != r0) return;
    end
    expire(tag);
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 200; i++) begin
      tick();
      if (VALID === 1'b1) begin
        valid_cyc = cyc;
        return;
      end
    end
    expire(tag);
  endtask

  task automatic push(input string tag, input int dmin, input int dmax, input bit tout, input bit din1);
    exp_t e;
    e.tag = tag; e.dmin = dmin; e.dmax = dmax; e.tout = tout; e.din1 = din1;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      expire("scoreboard_underflow");
      return;
    end
    e = sb.pop_front();
    chk({e.tag, "_dist_in_range"}, (int'(DIST) >= e.dmin && int'(DIST) <= e.dmax), 1);
    chk({e.tag, "_tout"}, TOUT, e.tout);
    chk({e.tag, "_din1"}, DIN1, e.din1);
  endtask

  // One triggered measurement with an echo of `width` cycles starting `delay` cycles after TRIG falls.
  task automatic measure(input string tag, input int delay, input int width, input bit din1);
    wait_fall({tag, "_trig_fall"});
    if (width < THRESH_CYC) push(tag, width - 2, width + 2, 1'b0, din1);
    else                    push(tag, width - 2, width + 2, 1'b0, din1);
    repeat (delay) tick();
    ECHO = 1'b1;
    repeat (width) tick();
    ECHO = 1'b0;
    wait_valid({tag, "_valid"});
    pop_check();
  endtask

  initial begin
    int rel, r0, rc0, en_cyc;
    rst = 1'b1; EN_D = 1'b0; ECHO = 1'b0;
    repeat (3) tick();
    chk("rst_trig", TRIG, 0);
    chk("rst_din1", DIN1, 0);
    chk("rst_dist", DIST, 0);
    chk("rst_valid", VALID, 0);
    chk("rst_tout", TOUT, 0);

    rst = 1'b0;
    rel = cyc;
    wait_rise("first_rise");
    chk("first_trig_delay", rise_cyc - rel, PERIOD_CYC);

    // 60-cycle echo: far, flag stays low; outputs hold after the strobe.
    measure("echo60", 10, 60, 1'b0);
    tick();
    chk("valid_one_cycle", VALID, 0);
    repeat (5) tick();
    chk("dist_hold", (DIST >= 21'd58 && DIST <= 21'd62), 1);
    chk("tout_hold", TOUT, 0);

    // single near then far: no change; then two nears: flag rises on the second.
    measure("near_single", 10, 20, 1'b0);
    measure("far_after_single", 10, 60, 1'b0);
    measure("near_first", 10, 20, 1'b0);
    measure("near_second", 10, 20, 1'b1);

    // echo never arrives: timeout at fixed latency, counted as far (first far keeps flag).
    wait_fall("tout_low_fall");
    push("tout_low", DMAX, DMAX, 1'b1, 1'b1);
    wait_valid("tout_low_valid");
    chk("timeout_latency", valid_cyc - fall_cyc, TIMEOUT_CYC);
    pop_check();

    // echo stuck high: timeout in MEASURE, second far clears flag, period spacing kept.
    wait_fall("stuck_fall");
    ECHO = 1'b1;
    r0 = rise_cyc;
    push("stuck_high", DMAX, DMAX, 1'b1, 1'b0);
    wait_valid("stuck_valid");
    pop_check();
    wait_rise("stuck_next_rise");
    chk("period_spacing", rise_cyc - r0, PERIOD_CYC);
    ECHO = 1'b0;

    // disable during MEASURE: strobe still arrives, then no trigger until re-enabled.
    wait_fall("dis_fall");
    push("disable_mid", 58, 62, 1'b0, 1'b0);
    repeat (10) tick();
    ECHO = 1'b1;
    repeat (20) tick();
    EN_D = 1'b1;
    repeat (40) tick();
    ECHO = 1'b0;
    wait_valid("dis_valid");
    pop_check();
    rc0 = rise_cnt;
    repeat (500) tick();
    chk("no_trig_while_disabled", rise_cnt - rc0, 0);
    EN_D = 1'b0;
    en_cyc = cyc;
    wait_rise("enable_rise");
    chk("trig_after_enable", rise_cyc - en_cyc, PERIOD_CYC);

    measure("near_a", 10, 20, 1'b0);
    measure("near_b", 10, 20, 1'b1);

    // reset during MEASURE clears every output on the next edge.
    wait_fall("rst_mid_fall");
    repeat (10) tick();
    ECHO = 1'b1;
    repeat (20) tick();
    rst = 1'b1;
    tick();
    chk("midrst_trig", TRIG, 0);
    chk("midrst_din1", DIN1, 0);
    chk("midrst_dist", DIST, 0);
    chk("midrst_valid", VALID, 0);
    chk("midrst_tout", TOUT, 0);
    tick();
    ECHO = 1'b0;
    rst = 1'b0;
    rel = cyc;
    wait_rise("midrst_rise");
    chk("midrst_trig_delay", rise_cyc - rel, PERIOD_CYC);

    chk("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
